// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if
// Request handshakes (encrypt / decrypt) and the result handshake of the
// AES round sequencer. The requester/consumer side uses the master modport,
// the sequencer uses the slave modport.
interface aes_round_sequencer_if;
  logic enc_valid;
  logic enc_ready;
  logic dec_valid;
  logic dec_ready;
  logic out_valid;
  logic out_ready;
  logic out_is_dec;

  modport master (
    output enc_valid, dec_valid, out_ready,
    input  enc_ready, dec_ready, out_valid, out_is_dec
  );

  modport slave (
    input  enc_valid, dec_valid, out_ready,
    output enc_ready, dec_ready, out_valid, out_is_dec
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
// Control FSM for one shared iterative AES round datapath. Arbitrates between
// an encrypt and a decrypt requester, then walks the datapath through the
// initial AddRoundKey, Nr-1 full rounds and the final round while driving the
// round-key index, and finally holds the result under a valid/ready handshake.
// Optional feature: define AES_SEQ_RR_EN for round-robin arbitration; when it
// is undefined, encrypt has fixed priority over decrypt.
// The reset input 'reset' is asynchronous and active-low.
module aes_round_sequencer #(
  parameter int Nr = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  aes_round_sequencer_if.slave        bus,
  input  logic                        i_flush,
  output logic                        o_mode_dec,
  output logic                        o_ld_in,
  output logic                        o_rnd_en,
  output logic                        o_rnd_last,
  output logic [3:0]                  o_rk_idx,
  output logic                        o_busy
);

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, HOLD} state_t;

  localparam logic [3:0] NrIdx = 4'(Nr);
  localparam logic [3:0] NrM1  = 4'(Nr - 1);

  state_t     r_state;
  logic       r_modeDec;
  logic       r_ldIn;
  logic       r_rndEn;
  logic       r_rndLast;
  logic [3:0] r_rkIdx;
  logic       r_busy;
  logic       r_outValid;
  logic       r_outIsDec;

  logic       w_encWin;
  logic       w_decWin;
  logic       w_idle;
  logic       w_grant;
  logic       w_roundDone;

`ifdef AES_SEQ_RR_EN
  logic       r_lastDec;

  // Round-robin winner: on a tie the side that was not served last wins.
  always_comb begin
    w_encWin = bus.enc_valid && (!bus.dec_valid || r_lastDec);
    w_decWin = bus.dec_valid && (!bus.enc_valid || !r_lastDec);
  end
`else
  // Fixed-priority winner: encrypt always beats decrypt.
  always_comb begin
    w_encWin = bus.enc_valid;
    w_decWin = bus.dec_valid && !bus.enc_valid;
  end
`endif

  // Ready is offered only in IDLE and is forced low while reset is asserted.
  assign w_idle        = reset && (r_state == IDLE);
  assign bus.enc_ready = w_idle && w_encWin;
  assign bus.dec_ready = w_idle && w_decWin;
  assign w_grant       = bus.enc_ready || bus.dec_ready;

  // The last full round uses key Nr-1 when encrypting and key 1 when decrypting.
  assign w_roundDone = r_modeDec ? (r_rkIdx == 4'd1) : (r_rkIdx == NrM1);

  // Sequencer FSM: state, datapath strobes, key index and result flags all registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_modeDec  <= 1'b0;
      r_ldIn     <= 1'b0;
      r_rndEn    <= 1'b0;
      r_rndLast  <= 1'b0;
      r_rkIdx    <= 4'd0;
      r_busy     <= 1'b0;
      r_outValid <= 1'b0;
      r_outIsDec <= 1'b0;
`ifdef AES_SEQ_RR_EN
      r_lastDec  <= 1'b1;
`endif
    end else if (i_flush && (r_state != IDLE)) begin
      r_state    <= IDLE;
      r_ldIn     <= 1'b0;
      r_rndEn    <= 1'b0;
      r_rndLast  <= 1'b0;
      r_busy     <= 1'b0;
      r_outValid <= 1'b0;
      r_outIsDec <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state   <= INIT;
            r_modeDec <= w_decWin;
            r_ldIn    <= 1'b1;
            r_busy    <= 1'b1;
            r_rkIdx   <= w_decWin ? NrIdx : 4'd0;
`ifdef AES_SEQ_RR_EN
            r_lastDec <= w_decWin;
`endif
          end
        end
        INIT: begin
          r_state <= ROUND;
          r_ldIn  <= 1'b0;
          r_rndEn <= 1'b1;
          r_rkIdx <= r_modeDec ? NrM1 : 4'd1;
        end
        ROUND: begin
          if (w_roundDone) begin
            r_state   <= FINAL;
            r_rndEn   <= 1'b0;
            r_rndLast <= 1'b1;
            r_rkIdx   <= r_modeDec ? 4'd0 : NrIdx;
          end else begin
            r_rkIdx <= r_modeDec ? (r_rkIdx - 4'd1) : (r_rkIdx + 4'd1);
          end
        end
        FINAL: begin
          r_state    <= HOLD;
          r_rndLast  <= 1'b0;
          r_outValid <= 1'b1;
          r_outIsDec <= r_modeDec;
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_outIsDec <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_mode_dec     = r_modeDec;
  assign o_ld_in        = r_ldIn;
  assign o_rnd_en       = r_rndEn;
  assign o_rnd_last     = r_rndLast;
  assign o_rk_idx       = r_rkIdx;
  assign o_busy         = r_busy;
  assign bus.out_valid  = r_outValid;
  assign bus.out_is_dec = r_outIsDec;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer
// Randomized bench for aes_round_sequencer. A driver issues requests and, from
// its own arbitration model and the AES key-schedule order, pushes the expected
// datapath events into a queue; a monitor pops them as the DUT shows strobes
// or completes a result handshake. A second instance with Nr=14 runs a single
// directed decrypt.
module tb_aes_round_sequencer;
  localparam int NR   = 10;
  localparam int NR14 = 14;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_sequencer_if bus();
  logic       flush;
  logic       modeDec, ldIn, rndEn, rndLast, busy;
  logic [3:0] rkIdx;

  aes_round_sequencer #(.Nr(NR)) dut (
    .clk(clk), .reset(reset), .bus(bus), .i_flush(flush),
    .o_mode_dec(modeDec), .o_ld_in(ldIn), .o_rnd_en(rndEn),
    .o_rnd_last(rndLast), .o_rk_idx(rkIdx), .o_busy(busy)
  );

  aes_round_sequencer_if bus14();
  logic       flush14;
  logic       modeDec14, ldIn14, rndEn14, rndLast14, busy14;
  logic [3:0] rkIdx14;

  aes_round_sequencer #(.Nr(NR14)) dut14 (
    .clk(clk), .reset(reset), .bus(bus14), .i_flush(flush14),
    .o_mode_dec(modeDec14), .o_ld_in(ldIn14), .o_rnd_en(rndEn14),
    .o_rnd_last(rndLast14), .o_rk_idx(rkIdx14), .o_busy(busy14)
  );

  int checks = 0;
  int errors = 0;

  // Expected event: kind 0=load, 1=full round, 2=final round, 3=result accepted.
  typedef struct {
    int kind;
    int rk;
    int isDec;
    int at;
  } ev_t;
  ev_t expQ[$];

  bit mLastDec = 1'b1;
  bit d14Done  = 1'b0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushEv(input int kind, input int rk, input int isDec, input int at);
    ev_t e;
    e.kind = kind; e.rk = rk; e.isDec = isDec; e.at = at;
    expQ.push_back(e);
  endtask

  // Reference arbitration: fixed encrypt priority, or alternate on ties.
  function automatic bit predictDec(input bit e, input bit d);
`ifdef AES_SEQ_RR_EN
    if (e && d) return !mLastDec;
`endif
    return d && !e;
  endfunction

  // Issues one request at the current IDLE cycle and follows the block to its end.
  task automatic applyStimulus(input bit encV, input bit decV, input int holdLow,
                               input int flushRound, input bit rstFinal);
    bit gDec;
    int hs;
    gDec = predictDec(encV, decV);
    bus.enc_valid = encV;
    bus.dec_valid = decV;
    bus.out_ready = (holdLow == 0);
    hs = cyc + 1;
    #1;
    checkOutput("enc_ready_grant", int'(bus.enc_ready), int'(!gDec));
    checkOutput("dec_ready_grant", int'(bus.dec_ready), int'(gDec));
    mLastDec = gDec;
    pushEv(0, gDec ? NR : 0, int'(gDec), hs);
    for (int i = 1; i < NR; i++)
      if (flushRound == 0 || i <= flushRound)
        pushEv(1, gDec ? NR - i : i, int'(gDec), hs + i);
    if (flushRound == 0) begin
      pushEv(2, gDec ? 0 : NR, int'(gDec), hs + NR);
      if (!rstFinal) pushEv(3, 0, int'(gDec), hs + NR + 1 + holdLow);
    end
    for (int k = 1; k <= NR + 2 + holdLow; k++) begin
      @(negedge clk);
      if (flushRound > 0 && k == flushRound + 2) begin
        flush = 1'b0;
        bus.enc_valid = 1'b0;
        bus.dec_valid = 1'b0;
        #1;
        checkOutput("flush_busy", int'(busy), 0);
        checkOutput("flush_out_valid", int'(bus.out_valid), 0);
        return;
      end
      bus.enc_valid = 1'($urandom_range(0, 1));
      bus.dec_valid = 1'($urandom_range(0, 1));
      if (flushRound > 0 && k == flushRound + 1) flush = 1'b1;
      if (k == NR + 2 + holdLow) bus.out_ready = 1'b1;
      if (rstFinal && k == NR + 1) begin
        bus.enc_valid = 1'b1;
        bus.dec_valid = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        checkOutput("reset_outputs",
                    int'({bus.enc_ready, bus.dec_ready, ldIn, rndEn, rndLast,
                          busy, bus.out_valid, bus.out_is_dec}), 0);
        checkOutput("reset_rk_mode", int'({modeDec, rkIdx}), 0);
        mLastDec = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      #1;
      checkOutput("busy_enc_ready", int'(bus.enc_ready), 0);
      checkOutput("busy_dec_ready", int'(bus.dec_ready), 0);
      checkOutput("busy_flag", int'(busy), 1);
      if (k == 1) checkOutput("mode_dec", int'(modeDec), int'(gDec));
      if (flushRound == 0 && k >= NR + 2) checkOutput("hold_out_valid", int'(bus.out_valid), 1);
    end
    @(negedge clk);
    bus.enc_valid = 1'b0;
    bus.dec_valid = 1'b0;
    #1;
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("idle_out_valid", int'(bus.out_valid), 0);
  endtask

  // Monitor: pops the expected event whenever the DUT shows a strobe or hands over a result.
  initial begin
    ev_t e;
    int n, kindAct;
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b1) begin
        n = int'(ldIn) + int'(rndEn) + int'(rndLast);
        if (n > 0) begin
          checkOutput("strobe_onehot", int'(n <= 1), 1);
          if (expQ.size() == 0) begin
            checkOutput("unexpected_strobe", n, 0);
          end else begin
            e = expQ.pop_front();
            kindAct = ldIn ? 0 : (rndEn ? 1 : 2);
            checkOutput("strobe_kind", kindAct, e.kind);
            checkOutput("rk_idx", int'(rkIdx), e.rk);
            checkOutput("strobe_cycle", cyc, e.at);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_result", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("result_kind", 3, e.kind);
            checkOutput("out_is_dec", int'(bus.out_is_dec), e.isDec);
            checkOutput("result_cycle", cyc, e.at);
          end
        end
      end
    end
  end

  // Directed Nr=14 decrypt on the second instance.
  initial begin
    int rndCount;
    bus14.enc_valid = 1'b0;
    bus14.dec_valid = 1'b0;
    bus14.out_ready = 1'b1;
    flush14 = 1'b0;
    rndCount = 0;
    repeat (4) @(negedge clk);
    bus14.dec_valid = 1'b1;
    #1;
    checkOutput("n14_dec_ready", int'(bus14.dec_ready), 1);
    checkOutput("n14_enc_ready", int'(bus14.enc_ready), 0);
    for (int k = 1; k <= NR14 + 2; k++) begin
      @(negedge clk);
      bus14.dec_valid = 1'b0;
      #2;
      if (rndEn14) rndCount++;
      if (k == 1) begin
        checkOutput("n14_ld", int'({ldIn14, rndEn14, rndLast14}), 4);
        checkOutput("n14_rk_ld", int'(rkIdx14), NR14);
      end else if (k <= NR14) begin
        checkOutput("n14_rnd", int'({ldIn14, rndEn14, rndLast14}), 2);
        checkOutput("n14_rk_rnd", int'(rkIdx14), NR14 + 1 - k);
      end else if (k == NR14 + 1) begin
        checkOutput("n14_last", int'({ldIn14, rndEn14, rndLast14}), 1);
        checkOutput("n14_rk_last", int'(rkIdx14), 0);
      end else begin
        checkOutput("n14_out", int'({bus14.out_valid, bus14.out_is_dec}), 3);
      end
    end
    checkOutput("n14_round_count", rndCount, NR14 - 1);
    d14Done = 1'b1;
  end

  // Main stimulus sequence.
  initial begin
    bit ev, dv;
    reset = 1'b0;
    flush = 1'b0;
    bus.enc_valid = 1'b1;
    bus.dec_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("init_reset_outputs",
                int'({bus.enc_ready, bus.dec_ready, ldIn, rndEn, rndLast,
                      busy, bus.out_valid, bus.out_is_dec}), 0);
    checkOutput("init_reset_rk_mode", int'({modeDec, rkIdx}), 0);
    @(negedge clk);
    reset = 1'b1;
    bus.enc_valid = 1'b0;
    bus.dec_valid = 1'b0;

    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b1, 0, 0, 1'b0);
    for (int b = 0; b < 4; b++) applyStimulus(1'b1, 1'b1, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 5, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 4, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 0, 1'b0);

    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("idle_flush_busy", int'(busy), 0);
    applyStimulus(1'b0, 1'b1, 1, 0, 1'b0);

    for (int b = 0; b < 20; b++) begin
      ev = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      if (!ev && !dv) ev = 1'b1;
      applyStimulus(ev, dv, $urandom_range(0, 3),
                    ($urandom_range(0, 5) == 0) ? $urandom_range(1, NR - 1) : 0, 1'b0);
    end

    applyStimulus(1'b0, 1'b1, 0, 0, 1'b1);
    applyStimulus(1'b1, 1'b1, 0, 0, 1'b0);

    for (int w = 0; w < 100 && !d14Done; w++) @(negedge clk);
    checkOutput("n14_finished", int'(d14Done), 1);
    repeat (2) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Control FSM for one shared iterative AES round datapath: it arbitrates between an encrypt requester and a decrypt requester and sequences the datapath through the initial AddRoundKey, the Nr-1 full rounds and the final round. It also drives the round-key index into the KeyExpansion word bus and presents the result with a valid/ready handshake. It sits between the block-level request interfaces and the round datapath, replacing free-running round counters inside the datapath.

## Interface
- Nr, default 10: number of AES rounds; legal values are 10, 12 and 14.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enc_valid  in  1  encrypt request pending.
- enc_ready  out  1  encrypt request accepted this cycle.
- dec_valid  in  1  decrypt request pending.
- dec_ready  out  1  decrypt request accepted this cycle.
- flush  in  1  synchronous abort; the in-flight block is dropped.
- mode_dec  out  1  datapath direction; 1 = decrypt, registered at grant.
- ld_in  out  1  datapath loads the input block and applies the initial AddRoundKey.
- rnd_en  out  1  datapath applies one full round.
- rnd_last  out  1  datapath applies the final round (no MixColumns / InvMixColumns).
- rk_idx  out  4  round-key index; the datapath selects word[128*rk_idx +: 128].
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  result block valid at the datapath output.
- out_ready  in  1  consumer accepts the result.
- out_is_dec  out  1  result came from a decrypt request; valid with out_valid.

## Operation
- FSM states are IDLE, INIT, ROUND, FINAL and HOLD.
- IDLE:
  - The FSM picks a winner among the asserted *_valid inputs.
  - Only the winner's *_ready is driven high, combinationally, in IDLE only.
  - On a handshake (valid && ready), mode_dec is latched and the FSM moves to INIT.
- INIT (1 cycle):
  - ld_in=1.
  - rk_idx is 0 for encrypt and Nr for decrypt.
  - The next state is ROUND.
- ROUND (Nr-1 cycles):
  - rnd_en=1.
  - Encrypt: rk_idx counts 1, 2, …, Nr-1.
  - Decrypt: rk_idx counts Nr-1, Nr-2, …, 1.
  - After the (Nr-1)th ROUND cycle the FSM moves to FINAL.
- FINAL (1 cycle):
  - rnd_last=1.
  - rk_idx is Nr for encrypt and 0 for decrypt.
  - The next state is HOLD.
- HOLD:
  - out_valid=1 and out_is_dec=mode_dec, held until out_ready.
  - On out_ready the FSM returns to IDLE.
  - No new request is accepted in the same cycle.
- rk_idx is a 4-bit counter and never leaves the range 0..Nr.
  - In IDLE and HOLD it holds its last value.
  - The datapath ignores rk_idx while ld_in, rnd_en and rnd_last are all low.
- At most one of ld_in, rnd_en and rnd_last is high in any cycle.
- flush:
  - It has priority over every transition. The next state is IDLE, and out_valid drops on the next edge.
  - No result is presented for the aborted block, and the arbitration pointer is not updated.
  - A flush asserted in IDLE has no effect.
- Reset, asynchronous (including mid-operation):
  - The FSM goes to IDLE, mode_dec=0, rk_idx=0, and the arbitration pointer = "last served decrypt".
  - All outputs go low: ready, ld_in, rnd_en, rnd_last, busy, out_valid and out_is_dec.

## Timing
- Latency: a handshake at edge t gives INIT in cycle t+1, ROUND in cycles t+2..t+Nr, FINAL in cycle t+Nr+1, and out_valid from cycle t+Nr+2.
- Minimum occupancy is Nr+3 cycles per block, counting the HOLD cycle with out_ready already high and the IDLE cycle.
- Dropping *_valid once the FSM has left IDLE has no effect; the request is already captured.
- The datapath must register its state on the same edge on which the strobes are high.

## Configuration
- `AES_SEQ_RR_EN` defined:
  - Round-robin arbitration. On simultaneous requests the grant goes to the side not served last.
  - The pointer updates on each completed handshake.
- Undefined:
  - Fixed priority, encrypt over decrypt; the pointer logic is not instantiated.
  - A continuous encrypt stream starves decrypt.

## Test plan
- Nr=10, single encrypt, out_ready held high:
  - ld_in appears 1 cycle after the handshake with rk_idx=0.
  - rnd_en is high for 9 cycles with rk_idx 1..9.
  - rnd_last is high with rk_idx=10.
  - out_valid is high at t+12 with out_is_dec=0.
- Nr=14, single decrypt:
  - rk_idx runs 14, 13..1, 0.
  - 13 rnd_en cycles.
  - out_is_dec=1.
- enc_valid and dec_valid both held high for 4 blocks:
  - With `AES_SEQ_RR_EN` the grants are enc, dec, enc, dec.
  - Without it the grants are enc, enc, enc, enc.
- out_ready low for 5 cycles in HOLD:
  - out_valid is held for 5 cycles and enc_ready/dec_ready stay 0.
  - The FSM returns to IDLE one cycle after out_ready rises.
- flush in the 4th ROUND cycle:
  - Next cycle the FSM is in IDLE with busy=0, and no out_valid appears.
  - The next request restarts with ld_in.
- reset low in the middle of FINAL:
  - All outputs are 0 immediately, before the next clock edge.
  - After release, the first simultaneous request is granted to encrypt.
